// File: rtl/mobo_copy_seq_pkg.sv
// rtl/mobo_copy_seq_pkg.sv - shared state encodings, mode codes and control pin indices
package mobo_copy_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_WR,
        S_RAM_WR_WAIT,
        S_RAM_RD,
        S_RAM_RD_WAIT,
        S_VGA_WR,
        S_VGA_WAIT,
        S_DONE
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int RAM_READ_PIN  = 0;
    localparam int RAM_WRITE_PIN = 1;
    localparam int RAM_ACK       = 0;
    localparam int VGA_WRITE_PIN = 0;
    localparam int VGA_ACK       = 0;

    function automatic logic [31:0] pin_mask(input int bit_idx);
        pin_mask = 32'h1 << bit_idx;
    endfunction

endpackage

// File: rtl/mobo_copy_seq_if.sv
// rtl/mobo_copy_seq_if.sv - shared mobo bus: RAM/VGA control and status words plus addr/data
interface mobo_copy_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [31:0]       ram_stat;
    logic [31:0]       ram_ctrl;
    logic [31:0]       vga_stat;
    logic [31:0]       vga_ctrl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output ram_ctrl, vga_ctrl, addr, data_out,
        input  ram_stat, vga_stat, data_in
    );

    modport slave (
        input  ram_ctrl, vga_ctrl, addr, data_out,
        output ram_stat, vga_stat, data_in
    );
endinterface

// File: rtl/mobo_copy_seq_handshake.sv
// rtl/mobo_copy_seq_handshake.sv - 4-phase request/ACK sequencing with per-phase timeout
// Phase 0 waits for ACK low then raises pin; phase 1 holds pin until ACK high (fin).
module bus_req_handshake #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic go_i,
    input  logic ack_i,
    output logic pin_o,
    output logic fin_o,
    output logic tmo_o
);
    localparam int TW = $clog2(TIMEOUT + 2);

    logic          ph_q, ph_d;
    logic          pin_q, pin_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          progress;

    always_comb begin
        progress = ph_q ? ack_i : ~ack_i;
        fin_o    = go_i & ph_q & ack_i;
        tmo_o    = 1'b0;
        // Fires on the cycle whose edge would bring the counter to TIMEOUT.
        if (TIMEOUT != 0) begin
            tmo_o = go_i & ~progress & (cnt_q == TW'(TIMEOUT - 1));
        end
        ph_d  = ph_q;
        pin_d = pin_q;
        cnt_d = cnt_q;
        if (!go_i || tmo_o) begin
            ph_d  = 1'b0;
            pin_d = 1'b0;
            cnt_d = '0;
        end else if (progress) begin
            ph_d  = ~ph_q;
            pin_d = ~ph_q;
            cnt_d = '0;
        end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q  <= 1'b0;
            pin_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ph_q  <= ph_d;
            pin_q <= pin_d;
            cnt_q <= cnt_d;
        end
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/mobo_copy_seq.sv
// rtl/mobo_copy_seq.sv - bus-master sequencer moving COUNT words RAM -> VGA (COPY or FILL+verify)
module mobo_copy_seq #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int CHAR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [ADDR_W-1:0]        src_base_i,
    input  logic [ADDR_W-1:0]        dst_base_i,
    input  logic [CNT_W-1:0]         count_i,
    input  logic [DATA_W-CHAR_W-1:0] attr_i,
    mobo_copy_seq_if.master          bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic [CNT_W-1:0]         idx_o
);
    import mobo_copy_seq_pkg::*;

    state_e                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [ADDR_W-1:0]         src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0]          count_q, count_d, idx_q, idx_d, err_cnt_q, err_cnt_d;
    logic [DATA_W-CHAR_W-1:0]  attr_q, attr_d;
    logic [CHAR_W-1:0]         rd_q, rd_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         dout_q, dout_d;
    logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic ram_ack, vga_ack, ram_go, vga_go;
    logic ram_pin, ram_fin, ram_tmo, vga_pin, vga_fin, vga_tmo;
    logic stat_unused;

    assign ram_ack     = bus.ram_stat[RAM_ACK];
    assign vga_ack     = bus.vga_stat[VGA_ACK];
    assign stat_unused = ^{bus.ram_stat, bus.vga_stat};
    assign ram_go      = (state_q == S_RAM_WR) || (state_q == S_RAM_WR_WAIT) ||
                         (state_q == S_RAM_RD) || (state_q == S_RAM_RD_WAIT);
    assign vga_go      = (state_q == S_VGA_WR) || (state_q == S_VGA_WAIT);

    bus_req_handshake #(.TIMEOUT(TIMEOUT)) u_ram_hs (
        .clk   (clk),
        .rst   (rst),
        .go_i  (ram_go),
        .ack_i (ram_ack),
        .pin_o (ram_pin),
        .fin_o (ram_fin),
        .tmo_o (ram_tmo)
    );

    bus_req_handshake #(.TIMEOUT(TIMEOUT)) u_vga_hs (
        .clk   (clk),
        .rst   (rst),
        .go_i  (vga_go),
        .ack_i (vga_ack),
        .pin_o (vga_pin),
        .fin_o (vga_fin),
        .tmo_o (vga_tmo)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        count_d   = count_q;
        attr_d    = attr_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                mode_d    = mode_i;
                src_d     = src_base_i;
                dst_d     = dst_base_i;
                count_d   = count_i;
                attr_d    = attr_i;
                idx_d     = '0;
                err_d     = 1'b0;
                err_cnt_d = '0;
                busy_d    = 1'b1;
                if (count_i == '0)             state_d = S_DONE;
                else if (mode_i == MODE_FILL)  state_d = S_RAM_WR;
                else                           state_d = S_RAM_RD;
            end
            S_RAM_WR: if (!ram_ack) begin
                addr_d  = src_q + ADDR_W'(idx_q);
                dout_d  = DATA_W'(idx_q);
                state_d = S_RAM_WR_WAIT;
            end
            S_RAM_WR_WAIT: if (ram_fin) state_d = S_RAM_RD;
            S_RAM_RD: if (!ram_ack) begin
                addr_d  = src_q + ADDR_W'(idx_q);
                state_d = S_RAM_RD_WAIT;
            end
            S_RAM_RD_WAIT: if (ram_fin) begin
                rd_d = bus.data_in[CHAR_W-1:0];
                if (mode_q == MODE_FILL && bus.data_in != DATA_W'(idx_q)) begin
                    err_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                state_d = S_VGA_WR;
            end
            S_VGA_WR: if (!vga_ack) begin
                addr_d  = dst_q + ADDR_W'(idx_q);
                dout_d  = {attr_q, rd_q};
                state_d = S_VGA_WAIT;
            end
            S_VGA_WAIT: if (vga_fin) begin
                if (idx_q == count_q - CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = (mode_q == MODE_FILL) ? S_RAM_WR : S_RAM_RD;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Only the active target's handshake can time out; idx keeps the failing word.
        if (ram_tmo || vga_tmo) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_COPY;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            attr_q    <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            attr_q    <= attr_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // The handshake pin is only high inside the matching *_WAIT state.
    assign bus.ram_ctrl = ((ram_pin && state_q == S_RAM_WR_WAIT) ? pin_mask(RAM_WRITE_PIN) : 32'd0) |
                          ((ram_pin && state_q == S_RAM_RD_WAIT) ? pin_mask(RAM_READ_PIN)  : 32'd0);
    assign bus.vga_ctrl = vga_pin ? pin_mask(VGA_WRITE_PIN) : 32'd0;
    assign bus.addr     = addr_q;
    assign bus.data_out = dout_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;
    assign idx_o        = idx_q;

endmodule

// File: tb/tb_mobo_copy_seq.sv
// tb/tb_mobo_copy_seq.sv - directed bench for mobo_copy_seq with RAM/VGA ACK responder
module tb_mobo_copy_seq;
    import mobo_copy_seq_pkg::*;

    logic        clk, rst, start, mode;
    logic [31:0] src_base, dst_base;
    logic [15:0] count;
    logic [23:0] attr;
    logic        busy, done, err;
    logic [15:0] err_cnt, idx;

    mobo_copy_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mobo_copy_seq #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16), .CHAR_W(8), .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .mode_i     (mode),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .count_i    (count),
        .attr_i     (attr),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_cnt_o  (err_cnt),
        .idx_o      (idx)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic        ram_hold_hi, vga_stuck;
    int          corrupt_addr;
    logic        ram_ack_r, vga_ack_r;
    logic [31:0] mem [0:255];
    logic [31:0] ev_q[$];
    logic [31:0] vga_addr_q[$];
    logic [31:0] vga_data_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // RAM at 0x100.. holds "A","B",... ; below that it is the write-backed store.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (int'(a) == corrupt_addr) return 32'd7;
        if (a >= 32'h100 && a < 32'h200) return 32'h41 + (a - 32'h100);
        return mem[a[7:0]];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            ram_ack_r   = 1'b0;
            vga_ack_r   = 1'b0;
            bus.data_in = 32'd0;
        end else begin
            if (ram_hold_hi) begin
                ram_ack_r = 1'b1;
            end else if (bus.ram_ctrl != 32'd0) begin
                if (!ram_ack_r) begin
                    if (bus.ram_ctrl[RAM_WRITE_PIN]) begin
                        mem[bus.addr[7:0]] = bus.data_out;
                        ev_q.push_back({4'd1, bus.addr[27:0]});
                    end else begin
                        bus.data_in = model_read(bus.addr);
                        ev_q.push_back({4'd2, bus.addr[27:0]});
                    end
                    ram_ack_r = 1'b1;
                end
            end else begin
                ram_ack_r = 1'b0;
            end
            if (vga_stuck) begin
                vga_ack_r = 1'b0;
            end else if (bus.vga_ctrl[VGA_WRITE_PIN]) begin
                if (!vga_ack_r) begin
                    vga_addr_q.push_back(bus.addr);
                    vga_data_q.push_back(bus.data_out);
                    ev_q.push_back({4'd3, bus.addr[27:0]});
                    vga_ack_r = 1'b1;
                end
            end else begin
                vga_ack_r = 1'b0;
            end
        end
        bus.ram_stat = 32'(ram_ack_r) << RAM_ACK;
        bus.vga_stat = 32'(vga_ack_r) << VGA_ACK;
    end

    task automatic start_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] c, input logic [23:0] a);
        mode = m; src_base = s; dst_base = d; count = c; attr = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int  pulses;
        bit  seen;
        pulses = 0;
        seen   = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; seen = 1'b1; end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check({tag, "_done_pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        int vb, eb, first, bcnt, cyc;
        bit act, ok;
        logic [31:0] exp_ev;

        rst = 1'b1; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0;
        count = '0; attr = '0; ram_hold_hi = 1'b0; vga_stuck = 1'b0; corrupt_addr = -1;
        repeat (3) @(posedge clk); #1;
        check("rst_ram_ctrl", bus.ram_ctrl, 0);
        check("rst_vga_ctrl", bus.vga_ctrl, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_flags", {busy, done, err}, 0);
        check("rst_err_cnt_idx", {err_cnt, idx}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // COPY 4 words 0x100.. -> 0x40.., attr 0x02
        vb = vga_addr_q.size();
        start_job(MODE_COPY, 32'h100, 32'h40, 16'd4, 24'h02);
        check("copy_busy", busy, 1);
        run_to_done("copy");
        check("copy_nwr", vga_addr_q.size() - vb, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("copy_addr%0d", i), vga_addr_q[vb + i], 32'h40 + i);
            check($sformatf("copy_data%0d", i), vga_data_q[vb + i], 32'h241 + i);
        end
        check("copy_err", err, 0);
        check("copy_idx", idx, 3);
        check("copy_busy_end", busy, 0);

        // FILL 3 words at 0, each verified before the VGA write
        eb = ev_q.size();
        start_job(MODE_FILL, 32'h0, 32'h80, 16'd3, 24'h0);
        run_to_done("fill");
        check("fill_nev", ev_q.size() - eb, 9);
        for (int i = 0; i < 3; i++) begin
            exp_ev = {4'd1, 28'(i)};
            check($sformatf("fill_ev_w%0d", i), ev_q[eb + 3*i], exp_ev);
            exp_ev = {4'd2, 28'(i)};
            check($sformatf("fill_ev_r%0d", i), ev_q[eb + 3*i + 1], exp_ev);
            exp_ev = {4'd3, 28'(32'h80 + i)};
            check($sformatf("fill_ev_v%0d", i), ev_q[eb + 3*i + 2], exp_ev);
        end
        check("fill_mem1", mem[1], 1);
        check("fill_err", err, 0);
        check("fill_err_cnt", err_cnt, 0);

        // FILL with the readback of address 1 corrupted to 7
        corrupt_addr = 1;
        vb = vga_addr_q.size();
        start_job(MODE_FILL, 32'h0, 32'h80, 16'd3, 24'h0);
        run_to_done("fillbad");
        corrupt_addr = -1;
        check("fillbad_err", err, 1);
        check("fillbad_err_cnt", err_cnt, 1);
        check("fillbad_nwr", vga_addr_q.size() - vb, 3);
        check("fillbad_data1", vga_data_q[vb + 1], 32'h7);
        check("fillbad_data2", vga_data_q[vb + 2], 32'h2);

        // count = 0: no bus traffic, done two cycles after start
        eb = ev_q.size();
        start_job(MODE_COPY, 32'h100, 32'h40, 16'd0, 24'h0);
        first = 0; bcnt = 0; act = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (done && first == 0) first = k;
            if (busy) bcnt++;
            if (bus.ram_ctrl != 0 || bus.vga_ctrl != 0) act = 1'b1;
        end
        check("zero_done_cycle", 64'(first), 2);
        check("zero_busy_cycles", 64'(bcnt), 1);
        check("zero_activity", act, 0);
        check("zero_events", ev_q.size() - eb, 0);
        check("zero_err", err, 0);

        // VGA ACK stuck low: timeout with TIMEOUT=16
        vga_stuck = 1'b1;
        start_job(MODE_COPY, 32'h100, 32'h40, 16'd1, 24'h0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk); #1;
            ok = (bus.vga_ctrl != 0);
        end
        check("tmo_pin_seen", ok, 1);
        cyc = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("tmo_done_cycle", 64'(cyc), 17);
        check("tmo_vga_ctrl", bus.vga_ctrl, 0);
        check("tmo_err", err, 1);
        check("tmo_idx", idx, 0);
        vga_stuck = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset while parked in VGA_WAIT
        vga_stuck = 1'b1;
        start_job(MODE_COPY, 32'h100, 32'h40, 16'd4, 24'h0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk); #1;
            ok = (bus.vga_ctrl != 0);
        end
        check("rstmid_pin_seen", ok, 1);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rstmid_ctrl", {bus.ram_ctrl, bus.vga_ctrl}, 0);
        check("rstmid_addr_data", {bus.addr, bus.data_out}, 0);
        check("rstmid_flags", {busy, done, err}, 0);
        check("rstmid_idx", idx, 0);
        vga_stuck = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vb = vga_addr_q.size();
        start_job(MODE_COPY, 32'h102, 32'h10, 16'd1, 24'h05);
        run_to_done("after_rst");
        check("after_rst_nwr", vga_addr_q.size() - vb, 1);
        check("after_rst_write", {vga_addr_q[vb], vga_data_q[vb]}, {32'h10, 32'h543});
        check("after_rst_err", err, 0);

        // RAM ACK held high across the start; second start while busy
        ram_hold_hi = 1'b1;
        repeat (2) @(posedge clk); #1;
        vb = vga_addr_q.size();
        eb = ev_q.size();
        start_job(MODE_COPY, 32'h101, 32'h20, 16'd1, 24'h0);
        repeat (4) @(posedge clk); #1;
        check("hold_ram_ctrl", bus.ram_ctrl, 0);
        check("hold_busy", busy, 1);
        start = 1'b1; count = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_ram_ctrl2", bus.ram_ctrl, 0);
        ram_hold_hi = 1'b0;
        run_to_done("hold");
        check("hold_nwr", vga_addr_q.size() - vb, 1);
        check("hold_write", {vga_addr_q[vb], vga_data_q[vb]}, {32'h20, 32'h42});
        check("hold_nev", ev_q.size() - eb, 2);
        check("hold_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
